grf_bypass: RTL and testbench
=============================

GRF_BYPASS -- requirements
Module: grf_bypass

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low; sampled on rising edge of clk.
REQ-003 A1  input  5  D-stage read address port 1 (InstrD rs).
REQ-004 A2  input  5  D-stage read address port 2 (InstrD rt).
REQ-005 RD1  output  32  read data port 1, combinational.
REQ-006 RD2  output  32  read data port 2, combinational.
REQ-007 WE  input  1  W-stage write enable (W instruction writes a GPR).
REQ-008 A3  input  5  W-stage destination register.
REQ-009 WD  input  32  W-stage write data.
REQ-010 SetEn  input  1  writer instruction leaves D this cycle (D stage not stalled).
REQ-011 SetAddr  input  5  destination of that writer (31 for jal, rt for lui/ori/lw, rd for addu/subu).
REQ-012 Busy1  output  1  A1 has an in-flight writer not yet written back, combinational.
REQ-013 Busy2  output  1  same for A2.

Function
REQ-014 Storage SHALL be 32 x 32-bit registers; register 0 SHALL read 0 always and SHALL ignore writes.
REQ-015 Write: on rising edge, if reset high and WE=1 and A3!=0, reg[A3] SHALL take WD.
REQ-016 Read: RDn SHALL equal reg[An], except internal bypass: if WE=1 and A3==An and An!=0, RDn SHALL equal WD in the same cycle (zero-latency write-through; W->D forwarding not needed elsewhere).
REQ-017 An=0 SHALL give RDn=0 regardless of WE/A3/WD.
REQ-018 Scoreboard: per register 1..31, a 2-bit pending counter cnt[r].
REQ-019 Per edge, inc = SetEn && SetAddr==r && r!=0; dec = WE && A3==r && r!=0.
REQ-020 inc only -> cnt+1; dec only -> cnt-1; both or neither -> unchanged.
REQ-021 Saturation: inc at cnt=3 SHALL hold 3; dec at cnt=0 SHALL hold 0 (no wrap).
REQ-022 cnt[0] SHALL be constant 0; SetAddr=0 or A3=0 SHALL not affect any counter.
REQ-023 Busyn SHALL be 1 iff An!=0 and (cnt[An] - dec_now(An)) != 0, where dec_now(An) = (WE && A3==An); i.e. a writer completing this cycle SHALL not count as busy, since its data is bypassed per REQ-016.
REQ-024 Busyn SHALL not include the SetEn/SetAddr of the current cycle (writer still in D).
REQ-025 Read ports SHALL be independent; A1==A2 SHALL give identical RD and Busy values.
REQ-026 Outputs SHALL have no dependence on clk beyond stored state (no registered outputs).

Reset
REQ-027 On rising edge with reset=0: all registers SHALL become 0 and all cnt SHALL become 0; concurrent WE and SetEn SHALL be ignored.
REQ-028 In the cycle after reset: RD1=RD2=0 for every address and Busy1=Busy2=0.
REQ-029 Reset asserted mid-operation (counters nonzero, write pending) SHALL clear all state identically; no partial write SHALL survive.

Verification
REQ-030 Reset, then WE=1 A3=5 WD=0x12345678, A1=5 same cycle -> RD1=0x12345678 combinationally; next cycle WE=0 -> RD1 still 0x12345678.
REQ-031 WE=1 A3=0 WD=0xFFFFFFFF, A1=0 A2=0 -> RD1=RD2=0 before and after edge; Busy1=Busy2=0.
REQ-032 SetEn SetAddr=31 (jal) edge, A1=31 -> Busy1=1; three edges later WE=1 A3=31 -> Busy1=0 in that cycle, RD1=WD; after edge cnt[31]=0.
REQ-033 Back-to-back SetEn SetAddr=8 on two edges -> cnt[8]=2; one WE A3=8 -> Busy on A2=8 still 1 next cycle; second WE -> 0.
REQ-034 Same-edge SetEn SetAddr=9 and WE A3=9 with cnt[9]=1 -> cnt[9] stays 1; four SetEn to reg 10 without WE -> cnt[10]=3 (saturate).
REQ-035 cnt[3]=2 and reg[3]=0xABCD, reset=0 edge -> next cycle A1=3 gives RD1=0, Busy1=0.

Source files
------------

// File: rtl/grf_bypass.sv
// 32x32 GPR file with W->D write-through bypass and a per-register pending-writer scoreboard.
// Reads/Busy are combinational (0 cycles), state updates on clk; no backpressure, every cycle is accepted.
module grf_bypass (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    input  logic        WE,
    input  logic [4:0]  A3,
    input  logic [31:0] WD,
    input  logic        SetEn,
    input  logic [4:0]  SetAddr,
    output logic        Busy1,
    output logic        Busy2
);

    logic [31:0] r_regs [32];
    logic [1:0]  r_cnt  [32];

    logic w_inc [32];
    logic w_dec [32];

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_inc[i] = 1'b0;
            w_dec[i] = 1'b0;
            if (i != 0) begin
                w_inc[i] = SetEn && (SetAddr == 5'(i));
                w_dec[i] = WE && (A3 == 5'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
                r_cnt[i]  <= 2'd0;
            end
        end else begin
            if (WE && (A3 != 5'd0)) begin
                r_regs[A3] <= WD;
            end
            // Simultaneous issue and retire of the same register cancel out.
            for (int i = 1; i < 32; i++) begin
                if (w_inc[i] && !w_dec[i] && (r_cnt[i] != 2'd3)) begin
                    r_cnt[i] <= r_cnt[i] + 2'd1;
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != 2'd0)) begin
                    r_cnt[i] <= r_cnt[i] - 2'd1;
                end
            end
        end
    end

    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = WE && (A3 == A1);
    assign w_hit2 = WE && (A3 == A2);

    always_comb begin
        RD1 = 32'd0;
        if (A1 != 5'd0) begin
            RD1 = w_hit1 ? WD : r_regs[A1];
        end
        RD2 = 32'd0;
        if (A2 != 5'd0) begin
            RD2 = w_hit2 ? WD : r_regs[A2];
        end
    end

    // A writer retiring this cycle is covered by the bypass, so it no longer counts as pending.
    assign Busy1 = (A1 != 5'd0) && (r_cnt[A1] > {1'b0, w_hit1});
    assign Busy2 = (A2 != 5'd0) && (r_cnt[A2] > {1'b0, w_hit2});

endmodule

// File: tb/tb_grf_bypass.sv
// Randomized + directed bench for grf_bypass with a queue-based scoreboard and an integer reference model.
module tb_grf_bypass;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, A3, SetAddr;
    logic [31:0] RD1, RD2, WD;
    logic        WE, SetEn, Busy1, Busy2;

    grf_bypass dut (
        .clk(clk), .reset(reset),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WE(WE), .A3(A3), .WD(WD),
        .SetEn(SetEn), .SetAddr(SetAddr),
        .Busy1(Busy1), .Busy2(Busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   drv_done = 0;

    // Reference model: plain register values and pending-writer counts.
    int unsigned m_mem [32];
    int          m_cnt [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int a, input bit we, input int a3, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && a3 == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input int a, input bit we, input int a3);
        int pending;
        if (a == 0) return 1'b0;
        pending = m_cnt[a] - ((we && a3 == a) ? 1 : 0);
        return pending > 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic step(input bit rst_n, input bit we, input int a3, input logic [31:0] wd,
                        input bit se, input int sa, input int a1, input int a2);
        exp_t e;
        reset = rst_n; WE = we; A3 = 5'(a3); WD = wd;
        SetEn = se; SetAddr = 5'(sa); A1 = 5'(a1); A2 = 5'(a2);
        e.rd1 = m_read(a1, we, a3, wd);
        e.rd2 = m_read(a2, we, a3, wd);
        e.b1  = m_busy(a1, we, a3);
        e.b2  = m_busy(a2, we, a3);
        exp_q.push_back(e);
        if (!rst_n) begin
            m_reset();
        end else begin
            if (we && a3 != 0) m_mem[a3] = wd;
            for (int r = 1; r < 32; r++) begin
                bit inc = se && (sa == r);
                bit dec = we && (a3 == r);
                if (inc && !dec && m_cnt[r] < 3) m_cnt[r] = m_cnt[r] + 1;
                if (dec && !inc && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int a1, input int a2);
        step(1, 0, 0, 32'd0, 0, 0, a1, a2);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("RD1",   RD1,   e.rd1);
                check("RD2",   RD2,   e.rd2);
                check("Busy1", {31'd0, Busy1}, {31'd0, e.b1});
                check("Busy2", {31'd0, Busy2}, {31'd0, e.b2});
            end
        end
    end

    initial begin
        int wait_cnt;
        reset = 0; WE = 0; A3 = 0; WD = 0; SetEn = 0; SetAddr = 0; A1 = 0; A2 = 0;
        m_reset();
        @(posedge clk); @(posedge clk); #1;

        // Reset ignores concurrent write/set; all reads zero afterwards.
        step(0, 1, 7, 32'h1111_2222, 1, 7, 7, 0);
        for (int a = 0; a < 32; a += 4) idle(a, a + 3);

        // Write-through then stored value.
        step(1, 1, 5, 32'h1234_5678, 0, 0, 5, 0);
        idle(5, 5);

        // Writes to r0 are discarded.
        step(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        idle(0, 0);

        // jal: set r31, retire three cycles later with bypass.
        step(1, 0, 0, 32'd0, 1, 31, 31, 0);
        idle(31, 0);
        idle(31, 0);
        step(1, 1, 31, 32'hCAFE_F00D, 0, 0, 31, 31);
        idle(31, 0);

        // Two outstanding writers to r8.
        step(1, 0, 0, 32'd0, 1, 8, 0, 8);
        step(1, 0, 0, 32'd0, 1, 8, 0, 8);
        step(1, 1, 8, 32'h0000_0808, 0, 0, 0, 8);
        idle(0, 8);
        step(1, 1, 8, 32'h0000_0888, 0, 0, 0, 8);
        idle(8, 8);

        // Same-edge set and retire on r9; saturation on r10.
        step(1, 0, 0, 32'd0, 1, 9, 9, 0);
        step(1, 1, 9, 32'h0000_0009, 1, 9, 9, 0);
        idle(9, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 32'd0, 1, 10, 10, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 10, 32'h0A0A_0000 + k, 0, 0, 10, 9);
        idle(10, 9);

        // Mid-operation reset clears data and counters.
        step(1, 1, 3, 32'h0000_ABCD, 1, 3, 3, 0);
        step(1, 0, 0, 32'd0, 1, 3, 3, 3);
        step(0, 1, 3, 32'h5555_5555, 1, 3, 3, 3);
        idle(3, 3);

        // Randomized traffic, addresses biased to a small set for collisions.
        for (int n = 0; n < 3000; n++) begin
            bit rst_n = ($urandom_range(0, 99) != 0);
            int hi    = ($urandom_range(0, 3) == 0) ? 31 : 6;
            step(rst_n, 1'($urandom_range(0, 1)), $urandom_range(0, hi), $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, hi),
                 $urandom_range(0, hi), $urandom_range(0, hi));
        end
        idle(0, 0);

        drv_done = 1;
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
